counter_dispatcher: RTL

Service-window scheduler for a bank of NCTR `counter` instances. Customers (ticket number, service time) are queued in an internal FIFO. Each cycle the head customer is issued to one idle counter, chosen round-robin, with a one-cycle load pulse. It sits between the ticket/entry logic and the counter bank and owns all counter `ld/dn/dt` drive.

---
 rtl/bank_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/counter_dispatcher.sv | 114 +++++++++++
 3 files changed

// File: rtl/bank_pkg.sv
// Shared defaults and customer record for the counter bank and its dispatcher.
package bank_pkg;

    localparam int unsigned NCTR_DEF  = 4;
    localparam int unsigned DN_SZ_DEF = 4;
    localparam int unsigned DT_SZ_DEF = 4;
    localparam int unsigned DEPTH_DEF = 8;

    typedef struct packed {
        logic [DN_SZ_DEF-1:0] dn;
        logic [DT_SZ_DEF-1:0] dt;
    } cust_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
    import bank_pkg::*;
#(
    parameter  int unsigned NCTR = NCTR_DEF,
    localparam int unsigned PW   = (NCTR > 1) ? $clog2(NCTR) : 1
) (
    input  logic [NCTR-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NCTR-1:0] grant,
    output logic            valid
);

    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NCTR; k++) begin
            idx = PW'((32'(ptr) + k) % NCTR);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_dispatcher.sv
// Queues customers in a FIFO and issues the head to an idle counter, round-robin,
// with a registered one-cycle load pulse.
module counter_dispatcher
    import bank_pkg::*;
#(
    parameter  int unsigned NCTR  = NCTR_DEF,
    parameter  int unsigned DN_SZ = DN_SZ_DEF,
    parameter  int unsigned DT_SZ = DT_SZ_DEF,
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned PW    = (NCTR > 1) ? $clog2(NCTR) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic [DN_SZ-1:0] enq_dn,
    input  logic [DT_SZ-1:0] enq_dt,
    output logic             enq_rdy,
    input  logic [NCTR-1:0]  ctr_busy,
    output logic [NCTR-1:0]  ctr_ld,
    output logic [DN_SZ-1:0] ctr_dn,
    output logic [DT_SZ-1:0] ctr_dt,
    output logic [AW:0]      q_cnt,
    output logic             full,
    output logic             empty,
    output logic [7:0]       served_cnt
);

    typedef struct packed {
        logic [DN_SZ-1:0] dn;
        logic [DT_SZ-1:0] dt;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [PW-1:0]   rr_ptr;

    logic [NCTR-1:0] eligible;
    logic [NCTR-1:0] grant;
    logic            grant_vld;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   next_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (q_cnt == (AW+1)'(DEPTH));
    assign empty   = (q_cnt == '0);
    assign enq_rdy = rst_n && !full;

    // A counter pulsed last cycle is not yet showing busy; exclude it explicitly.
    assign eligible = ~ctr_busy & ~ctr_ld;

    rr_arbiter #(.NCTR(NCTR)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_vld)
    );

    assign do_push = enq && enq_rdy;
    assign do_pop  = !empty && grant_vld;

    always_comb begin
        grant_idx = '0;
        for (int unsigned k = 0; k < NCTR; k++) begin
            if (grant[k]) begin
                grant_idx = PW'(k);
            end
        end
        next_ptr = (grant_idx == PW'(NCTR - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= '{dn: enq_dn, dt: enq_dt};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rr_ptr     <= '0;
            q_cnt      <= '0;
            ctr_ld     <= '0;
            ctr_dn     <= '0;
            ctr_dt     <= '0;
            served_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                ctr_ld     <= grant;
                ctr_dn     <= mem[rd_ptr].dn;
                ctr_dt     <= mem[rd_ptr].dt;
                rd_ptr     <= rd_ptr + 1'b1;
                rr_ptr     <= next_ptr;
                served_cnt <= served_cnt + 8'd1;
            end else begin
                ctr_ld <= '0;
                ctr_dn <= '0;
                ctr_dt <= '0;
            end
            case ({do_push, do_pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

endmodule
